// File: rtl/vga_timing_generator.sv
// Raster timing for the VGA colour path: pixel-rate counters, sync/blank decode,
// a latency-matching pipeline for sync/blank, and the registered, blank-gated colour output.
module vga_timing_generator #(
  parameter int   H_VISIBLE     = 640,
  parameter int   H_FRONT       = 16,
  parameter int   H_SYNC        = 96,
  parameter int   H_BACK        = 48,
  parameter int   V_VISIBLE     = 480,
  parameter int   V_FRONT       = 10,
  parameter int   V_SYNC        = 2,
  parameter int   V_BACK        = 33,
  parameter int   CLK_DIV       = 2,
  parameter int   COLOR_LATENCY = 1,
  parameter logic SYNC_ACTIVE   = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] red_in,
  input  logic [2:0] green_in,
  input  logic [1:0] blue_in,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       video_on,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  logic [1:0] div_cnt;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       line_end;
  logic       frame_end;
  logic [2:0] raw;
  logic [2:0] dly;
  logic [7:0] rgb_q;

  assign pixel_tick  = (div_cnt == DIV_LAST);
  assign line_end    = (hcount == H_LAST);
  assign frame_end   = line_end && (vcount == V_LAST);
  assign frame_start = pixel_tick && frame_end;
  assign xpos        = hcount;
  assign ypos        = vcount;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div_cnt     <= '0;
      hcount      <= '0;
      vcount      <= '0;
      frame_count <= '0;
    end else begin
      div_cnt <= pixel_tick ? 2'd0 : div_cnt + 2'd1;
      if (pixel_tick) begin
        hcount <= line_end ? 10'd0 : hcount + 10'd1;
        if (line_end) begin
          vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end
        if (frame_end) begin
          frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

  // {vis, hs, vs} for the position currently on xpos/ypos
  assign raw = {(hcount < H_VIS) && (vcount < V_VIS),
                (hcount >= HS_FIRST) && (hcount <= HS_LAST),
                (vcount >= VS_FIRST) && (vcount <= VS_LAST)};

  // Delay decode by the colour path's latency so blanking lines up with the colour it gates.
  if (COLOR_LATENCY == 0) begin : g_no_pipe
    assign dly = raw;
  end else begin : g_pipe
    logic [2:0] pipe [COLOR_LATENCY];

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        for (int i = 0; i < COLOR_LATENCY; i++) pipe[i] <= '0;
      end else if (pixel_tick) begin
        pipe[0] <= raw;
        for (int i = 1; i < COLOR_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign dly = pipe[COLOR_LATENCY-1];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      video_on <= 1'b0;
      hsync    <= ~SYNC_ACTIVE;
      vsync    <= ~SYNC_ACTIVE;
      rgb_q    <= '0;
    end else if (pixel_tick) begin
      video_on <= dly[2];
      hsync    <= dly[1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync    <= dly[0] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      rgb_q    <= dly[2] ? {red_in, green_in, blue_in} : 8'd0;
    end
  end

  assign red   = rgb_q[7:5];
  assign green = rgb_q[4:2];
  assign blue  = rgb_q[1:0];

endmodule
